// File: rtl/shot_link_pkg.sv
// Shared types and constants for the shot_link turn/message sequencer.
package shot_link_pkg;

  typedef enum logic [3:0] {
    ST_SETUP,
    ST_SEND_RDY,
    ST_WAIT_RDY,
    ST_MY_TURN,
    ST_SEND_SHOT,
    ST_WAIT_REPLY,
    ST_APPLY,
    ST_PEER_TURN,
    ST_PRESENT,
    ST_SAMPLE,
    ST_SEND_REPLY,
    ST_DONE
  } state_e;

  localparam logic [7:0] READY_BYTE = 8'hF0;
  localparam logic [3:0] REPLY_TAG  = 4'hA;

  localparam logic [1:0] MSG_MISS   = 2'b11;
  localparam logic [1:0] MSG_HIT    = 2'b10;
  localparam logic [1:0] MSG_REPEAT = 2'b00;

  // Board coordinate: both BCD-style nibbles must be 0..9.
  function automatic logic is_coord(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  // Reply byte: 0xA0..0xA3.
  function automatic logic is_reply(input logic [7:0] b);
    return (b[7:4] == REPLY_TAG) && (b[3:2] == 2'b00);
  endfunction

  // 4-bit counter increment that stops at lim.
  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v < lim) ? v + 4'd1 : v;
  endfunction

endpackage

// File: rtl/shot_link_tx_arb.sv
// link_tx_arb: one-entry transmit request register in front of the UART.
// A request is held until the transmitter is idle, then issued as a
// single-cycle tx_start; done pulses in that same cycle.
module link_tx_arb
  import shot_link_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] req_data,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       done
);

  logic       pend_q, pend_d;
  logic [7:0] pend_data_q, pend_data_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       have;
  logic [7:0] next_byte;

  // Merge a fresh request with the parked one and decide whether to launch.
  always_comb begin
    // NOTE: every _d gets its default first, so no path can infer a latch.
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    have        = pend_q || req;
    next_byte   = req ? req_data : pend_data_q;
    if (have) begin
      pend_data_d = next_byte;
      if (!tx_busy) begin
        tx_start_d = 1'b1;
        tx_data_d  = next_byte;
        pend_d     = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  // Request register and registered UART strobe; reset drops any pending send.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (rst) begin
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign done     = tx_start_q;

endmodule

// File: rtl/shot_link.sv
// shot_link: turn and message sequencer between the UART byte link and
// game_board. Optional feature macro: SHOT_TIMEOUT_EN (resend the shot when
// no reply arrives within TIMEOUT_CYCLES; retries are unlimited).
module shot_link
  import shot_link_pkg::*;
#(
  parameter int FIRST_MOVE     = 1,
  parameter int HITS_TO_WIN    = 11,
  parameter int TIMEOUT_CYCLES = 65_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [3:0] ship_count,
  input  logic       fire,
  input  logic [7:0] mouse_pos,
  input  logic [1:0] msg_out,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic [7:0] check_in,
  output logic       addres_recieved,
  output logic [1:0] msg_in,
  output logic       pick_place,
  output logic [7:0] shot_pos,
  output logic       won,
  output logic       lost
);

  localparam logic [3:0] WIN_CNT = 4'(HITS_TO_WIN);

  state_e     state_q, state_d;
  logic       rdy_seen_q, rdy_seen_d;
  logic       issued_q, issued_d;
  logic [7:0] shot_pos_q, shot_pos_d;
  logic [7:0] check_in_q, check_in_d;
  logic       addr_q, addr_d;
  logic [1:0] msg_in_q, msg_in_d;
  logic [1:0] verdict_q, verdict_d;
  logic       pick_place_q, pick_place_d;
  logic       won_q, won_d;
  logic       lost_q, lost_d;
  logic [3:0] hit_q, hit_d;
  logic [3:0] loss_q, loss_d;

  logic       tx_req;
  logic [7:0] tx_req_data;
  logic       tx_done;
  logic       rx_ready;

`ifdef SHOT_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] to_cnt_q, to_cnt_d;
`endif

  assign rx_ready = rx_valid && (rx_data == READY_BYTE);

  // Next-state, board strobes and tx requests for the game sequencer.
  always_comb begin
    state_d     = state_q;
    rdy_seen_d  = rdy_seen_q;
    shot_pos_d  = shot_pos_q;
    check_in_d  = check_in_q;
    addr_d      = addr_q;
    msg_in_d    = msg_in_q;
    verdict_d   = verdict_q;
    won_d       = won_q;
    lost_d      = lost_q;
    hit_d       = hit_q;
    loss_d      = loss_q;
    tx_req      = 1'b0;
    tx_req_data = READY_BYTE;

    case (state_q)
      ST_SETUP: begin
        if (rx_ready) rdy_seen_d = 1'b1;
        if (ship_count >= 4'd10) state_d = ST_SEND_RDY;
      end
      ST_SEND_RDY: begin
        if (rx_ready) rdy_seen_d = 1'b1;
        tx_req      = !issued_q;
        tx_req_data = READY_BYTE;
        if (tx_done) state_d = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (rdy_seen_q || rx_ready) begin
          rdy_seen_d = 1'b0;
          state_d    = (FIRST_MOVE != 0) ? ST_MY_TURN : ST_PEER_TURN;
        end
      end
      ST_MY_TURN: begin
        if (fire && is_coord(mouse_pos)) begin
          shot_pos_d = mouse_pos;
          state_d    = ST_SEND_SHOT;
        end
      end
      ST_SEND_SHOT: begin
        tx_req      = !issued_q;
        tx_req_data = shot_pos_q;
        if (tx_done) state_d = ST_WAIT_REPLY;
      end
      ST_WAIT_REPLY: begin
        if (rx_valid && is_reply(rx_data)) begin
          msg_in_d = rx_data[1:0];
          state_d  = ST_APPLY;
        end
`ifdef SHOT_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          state_d = ST_SEND_SHOT;
        end
`endif
      end
      ST_APPLY: begin
        // The board reads msg_in on the tick pixel; it clears one cycle later.
        if (frame_tick) begin
          msg_in_d = 2'b00;
          state_d  = ST_PEER_TURN;
          if (msg_in_q == MSG_HIT) begin
            hit_d = sat_inc(hit_q, WIN_CNT);
            if (sat_inc(hit_q, WIN_CNT) == WIN_CNT) begin
              won_d   = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_PEER_TURN: begin
        if (rx_valid && is_coord(rx_data)) begin
          check_in_d = rx_data;
          addr_d     = 1'b1;
          state_d    = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (frame_tick) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        // The board's verdict is valid the cycle after the tick; send it at once.
        verdict_d   = msg_out;
        addr_d      = 1'b0;
        tx_req      = 1'b1;
        tx_req_data = {REPLY_TAG, 2'b00, msg_out};
        state_d     = ST_SEND_REPLY;
      end
      ST_SEND_REPLY: begin
        if (tx_done) begin
          state_d = ST_MY_TURN;
          if (verdict_q == MSG_HIT) begin
            loss_d = sat_inc(loss_q, WIN_CNT);
            if (sat_inc(loss_q, WIN_CNT) == WIN_CNT) begin
              lost_d  = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_SETUP;
      end
    endcase

    // One request per visit to a send state; re-armed by leaving the state.
    issued_d     = (state_d == state_q) && (issued_q || tx_req);
    pick_place_d = state_d inside {ST_MY_TURN, ST_SEND_SHOT, ST_WAIT_REPLY, ST_APPLY};

`ifdef SHOT_TIMEOUT_EN
    to_cnt_d = (state_q == ST_WAIT_REPLY && state_d == ST_WAIT_REPLY) ? to_cnt_q + 32'd1 : 32'd0;
`endif
  end

  // FSM state, counters and registered board-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SETUP;
      rdy_seen_q   <= 1'b0;
      issued_q     <= 1'b0;
      shot_pos_q   <= '0;
      check_in_q   <= '0;
      addr_q       <= 1'b0;
      msg_in_q     <= 2'b00;
      verdict_q    <= 2'b00;
      pick_place_q <= 1'b0;
      won_q        <= 1'b0;
      lost_q       <= 1'b0;
      hit_q        <= '0;
      loss_q       <= '0;
`ifdef SHOT_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rdy_seen_q   <= rdy_seen_d;
      issued_q     <= issued_d;
      shot_pos_q   <= shot_pos_d;
      check_in_q   <= check_in_d;
      addr_q       <= addr_d;
      msg_in_q     <= msg_in_d;
      verdict_q    <= verdict_d;
      pick_place_q <= pick_place_d;
      won_q        <= won_d;
      lost_q       <= lost_d;
      hit_q        <= hit_d;
      loss_q       <= loss_d;
`ifdef SHOT_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  link_tx_arb u_tx_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (tx_req),
    .req_data (tx_req_data),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .done     (tx_done)
  );

  assign check_in        = check_in_q;
  assign addres_recieved = addr_q;
  assign msg_in          = msg_in_q;
  assign pick_place      = pick_place_q;
  assign shot_pos        = shot_pos_q;
  assign won             = won_q;
  assign lost            = lost_q;

endmodule

// File: tb/tb_shot_link.sv
// Testbench for shot_link: scoreboard of expected tx bytes popped on tx_start,
// plus direct checks of board-facing strobes.
module tb_shot_link;
  import shot_link_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic [3:0] ship_count;
  logic       fire;
  logic [7:0] mouse_pos;
  logic [1:0] msg_out;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [7:0] check_in;
  logic       addres_recieved;
  logic [1:0] msg_in;
  logic       pick_place;
  logic [7:0] shot_pos;
  logic       won;
  logic       lost;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         busy_cnt = 0;
  logic [7:0] last_peer = 8'h00;
  logic [7:0] last_shot = 8'h00;

  shot_link #(
    .FIRST_MOVE     (1),
    .HITS_TO_WIN    (11),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .ship_count      (ship_count),
    .fire            (fire),
    .mouse_pos       (mouse_pos),
    .msg_out         (msg_out),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .tx_busy         (tx_busy),
    .tx_data         (tx_data),
    .tx_start        (tx_start),
    .check_in        (check_in),
    .addres_recieved (addres_recieved),
    .msg_in          (msg_in),
    .pick_place      (pick_place),
    .shot_pos        (shot_pos),
    .won             (won),
    .lost            (lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART model and scoreboard: pop on every tx_start, then stay busy a few cycles.
  always @(posedge clk) begin
    #1;
    if (tx_start) begin
      check("tx_start_idle", 32'(tx_busy), 32'd0);
      check("tx_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      tx_busy  = 1'b1;
      busy_cnt = 3;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  task automatic do_fire(input logic [7:0] pos);
    mouse_pos = pos;
    fire      = 1'b1;
    tick();
    fire      = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_state(input string tag, input state_e s);
    check(tag, 32'(dut.state_q), 32'(s));
  endtask

  task automatic check_reset();
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_check_in", 32'(check_in), 32'd0);
    check("rst_addr", 32'(addres_recieved), 32'd0);
    check("rst_msg_in", 32'(msg_in), 32'd0);
    check("rst_pick_place", 32'(pick_place), 32'd0);
    check("rst_shot_pos", 32'(shot_pos), 32'd0);
    check("rst_won", 32'(won), 32'd0);
    check("rst_lost", 32'(lost), 32'd0);
    check_state("rst_state", ST_SETUP);
  endtask

  // Own shot, then the peer's reply applied on the next frame tick.
  task automatic my_round(input logic [7:0] pos, input logic [7:0] reply);
    exp_q.push_back(pos);
    do_fire(pos);
    last_shot = pos;
    drain("shot_tx");
    tick();
    send_rx(reply);
    check("reply_msg_in", 32'(msg_in), 32'(reply[1:0]));
    check("reply_pick", 32'(pick_place), 32'd1);
    pulse_tick();
    check("msg_in_cleared", 32'(msg_in), 32'd0);
  endtask

  // Peer shot presented to the board, board verdict returned as a reply byte.
  task automatic peer_round(input logic [7:0] pos, input logic [1:0] verdict);
    send_rx(pos);
    last_peer = pos;
    check("peer_check_in", 32'(check_in), 32'(pos));
    check("peer_addr", 32'(addres_recieved), 32'd1);
    tick();
    tick();
    check("peer_addr_held", 32'(addres_recieved), 32'd1);
    msg_out = verdict;
    pulse_tick();
    exp_q.push_back({REPLY_TAG, 2'b00, verdict});
    tick();
    check("reply_latency", 32'(tx_start), 32'd1);
    check("peer_addr_drop", 32'(addres_recieved), 32'd0);
    drain("reply_tx");
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    frame_tick = 1'b0;
    ship_count = 4'd0;
    fire       = 1'b0;
    mouse_pos  = 8'h00;
    msg_out    = MSG_REPEAT;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    tx_busy    = 1'b0;

    repeat (3) tick();
    check_reset();
    rst = 1'b0;

    // READY from the peer arrives early and is remembered.
    ship_count = 4'd5;
    repeat (2) tick();
    send_rx(READY_BYTE);
    tick();
    check_state("setup_wait", ST_SETUP);
    ship_count = 4'd10;
    exp_q.push_back(READY_BYTE);
    drain("ready_tx");
    repeat (3) tick();
    check("sync_pick", 32'(pick_place), 32'd1);
    check_state("sync_state", ST_MY_TURN);

    // Out-of-range click ignored; a valid click sends the shot two cycles later.
    do_fire(8'hA0);
    repeat (3) tick();
    check_state("bad_fire_state", ST_MY_TURN);
    check("bad_fire_pos", 32'(shot_pos), 32'd0);
    exp_q.push_back(8'h37);
    do_fire(8'h37);
    tick();
    check("shot_latency", 32'(tx_start), 32'd1);
    check("shot_pos", 32'(shot_pos), 32'h37);
    tick();
    check_state("wait_reply", ST_WAIT_REPLY);

    // Junk, shot and READY bytes are all dropped while awaiting a reply.
    send_rx(8'hB5);
    send_rx(8'h3C);
    send_rx(8'h45);
    send_rx(READY_BYTE);
    check_state("drop_state", ST_WAIT_REPLY);
    check("drop_msg_in", 32'(msg_in), 32'd0);
    check("drop_check_in", 32'(check_in), 32'd0);

    send_rx(8'hA2);
    check("hit_msg_in", 32'(msg_in), 32'(MSG_HIT));
    repeat (4) tick();
    check("hit_msg_held", 32'(msg_in), 32'(MSG_HIT));
    check("apply_pick", 32'(pick_place), 32'd1);
    pulse_tick();
    check("hit_msg_clear", 32'(msg_in), 32'd0);
    check_state("after_apply", ST_PEER_TURN);
    check("peer_pick", 32'(pick_place), 32'd0);

    peer_round(8'h45, MSG_MISS);
    check_state("back_my_turn", ST_MY_TURN);

    // Ten more hits reach HITS_TO_WIN = 11.
    for (int k = 0; k < 10; k++) begin
      my_round({4'(k), 4'(9 - k)}, 8'hA2);
      if (k < 9) peer_round({4'(9 - k), 4'(k)}, MSG_MISS);
    end
    check("won", 32'(won), 32'd1);
    check("won_lost", 32'(lost), 32'd0);
    check_state("won_state", ST_DONE);

    // DONE is absorbing: rx and fire dropped, nothing transmitted.
    send_rx(8'h12);
    do_fire(8'h11);
    send_rx(8'hA2);
    repeat (5) tick();
    check_state("done_state", ST_DONE);
    check("done_check_in", 32'(check_in), 32'(last_peer));
    check("done_shot_pos", 32'(shot_pos), 32'(last_shot));
    check("done_won", 32'(won), 32'd1);

    // Fresh game: this side loses after eleven hit verdicts sent back.
    rst = 1'b1;
    repeat (2) tick();
    exp_q.delete();
    check_reset();
    exp_q.push_back(READY_BYTE);
    rst = 1'b0;
    drain("ready_tx2");
    tick();
    send_rx(READY_BYTE);
    check("sync2_pick", 32'(pick_place), 32'd1);
    for (int k = 0; k < 11; k++) begin
      my_round({4'(k % 10), 4'd3}, 8'hA3);
      peer_round({4'd6, 4'(k % 10)}, MSG_HIT);
    end
    check("lost", 32'(lost), 32'd1);
    check("lost_won", 32'(won), 32'd0);
    check_state("lost_state", ST_DONE);

`ifdef SHOT_TIMEOUT_EN
    // No reply: the same shot is resent after TIMEOUT_CYCLES; reset abandons it.
    rst = 1'b1;
    repeat (2) tick();
    exp_q.delete();
    exp_q.push_back(READY_BYTE);
    rst = 1'b0;
    drain("ready_tx3");
    tick();
    send_rx(READY_BYTE);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h55);
    do_fire(8'h55);
    for (int i = 0; i < 50 && exp_q.size() != 1; i++) tick();
    check("first_shot", 32'(exp_q.size()), 32'd1);
    repeat (90) tick();
    check("no_early_resend", 32'(exp_q.size()), 32'd1);
    drain("resend");
    repeat (2) tick();
    check_state("to_wait_reply", ST_WAIT_REPLY);
    rst = 1'b1;
    tick();
    check_reset();
    rst = 1'b0;
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
